// File: rtl/sound_comm_latch.sv
// Main-CPU side of the 68k <-> 6502 sound communication port: command/reply
// latches, buffer-full and overrun flags, sound NMI pulse and sound reset hold.
module sound_comm_latch #(
  parameter int unsigned NMI_WIDTH  = 4,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] main_din,
  input  logic       main_wr_b,
  input  logic       main_rd_b,
  output logic [7:0] main_dout,
  output logic       main_irq,
  output logic [3:0] main_status,
  input  logic       ovr_clr,
  input  logic       snd_rst_req,
  output logic [7:0] SDin68k,
  input  logic [7:0] SDout68k,
  input  logic       WR68k_b,
  input  logic       RD68k_b,
  output logic       SNDNMI_b,
  output logic       ctrl_SNDBUF,
  output logic       ctrl_68kBUF,
  output logic       SNDRST_b
);

  localparam int unsigned NMI_CW = $clog2(NMI_WIDTH + 1);
  localparam int unsigned RST_CW = $clog2(RST_CYCLES + 1);

  typedef enum logic {ST_RUN, ST_HOLD} state_t;

  state_t              r_state;
  logic [RST_CW-1:0]   r_rst_cnt;
  logic [NMI_CW-1:0]   r_nmi_cnt;
  logic                r_main_wr_q;
  logic                r_main_rd_q;
  logic                r_snd_wr_q;
  logic                r_snd_rd_q;
  logic                r_snd_ovr;
  logic                r_main_ovr;

  logic w_main_wr_fall;
  logic w_main_rd_fall;
  logic w_snd_wr_fall;
  logic w_snd_rd_fall;
  logic w_hold;
  logic w_sndbuf_nxt;
  logic w_68kbuf_nxt;

  assign w_main_wr_fall = r_main_wr_q & ~main_wr_b;
  assign w_main_rd_fall = r_main_rd_q & ~main_rd_b;
  assign w_snd_wr_fall  = r_snd_wr_q  & ~WR68k_b;
  assign w_snd_rd_fall  = r_snd_rd_q  & ~RD68k_b;

  // A reset request takes effect on the edge it is sampled, not one cycle later.
  assign w_hold = (r_state == ST_HOLD) | snd_rst_req;

  assign main_status = {r_snd_ovr, r_main_ovr, ctrl_68kBUF, ctrl_SNDBUF};

  // Buffer-full flags: hold forces clear, otherwise set beats clear.
  always_comb begin
    w_sndbuf_nxt = ctrl_SNDBUF;
    w_68kbuf_nxt = ctrl_68kBUF;
    if (w_hold) begin
      w_sndbuf_nxt = 1'b0;
      w_68kbuf_nxt = 1'b0;
    end else begin
      if (w_main_wr_fall)     w_sndbuf_nxt = 1'b1;
      else if (w_snd_rd_fall) w_sndbuf_nxt = 1'b0;
      if (w_snd_wr_fall)       w_68kbuf_nxt = 1'b1;
      else if (w_main_rd_fall) w_68kbuf_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_rst_cnt   <= RST_CW'(RST_CYCLES);
      SNDRST_b    <= 1'b0;
      r_nmi_cnt   <= '0;
      SNDNMI_b    <= 1'b1;
      r_main_wr_q <= 1'b1;
      r_main_rd_q <= 1'b1;
      r_snd_wr_q  <= 1'b1;
      r_snd_rd_q  <= 1'b1;
      SDin68k     <= 8'h00;
      main_dout   <= 8'h00;
      ctrl_SNDBUF <= 1'b0;
      ctrl_68kBUF <= 1'b0;
      main_irq    <= 1'b0;
      r_snd_ovr   <= 1'b0;
      r_main_ovr  <= 1'b0;
    end else begin
      r_main_wr_q <= main_wr_b;
      r_main_rd_q <= main_rd_b;
      r_snd_wr_q  <= WR68k_b;
      r_snd_rd_q  <= RD68k_b;

      // Commands always latch, even while the sound side is held in reset.
      if (w_main_wr_fall) SDin68k <= main_din;
      if (!w_hold && w_snd_wr_fall) main_dout <= SDout68k;

      ctrl_SNDBUF <= w_sndbuf_nxt;
      ctrl_68kBUF <= w_68kbuf_nxt;
      main_irq    <= w_68kbuf_nxt;

      if (!w_hold && w_main_wr_fall && ctrl_SNDBUF) r_snd_ovr <= 1'b1;
      else if (ovr_clr)                             r_snd_ovr <= 1'b0;
      if (!w_hold && w_snd_wr_fall && ctrl_68kBUF)  r_main_ovr <= 1'b1;
      else if (ovr_clr)                             r_main_ovr <= 1'b0;

      // NMI pulse; a write during the pulse reloads and stretches it.
      if (w_hold) begin
        SNDNMI_b  <= 1'b1;
        r_nmi_cnt <= '0;
      end else if (w_main_wr_fall) begin
        SNDNMI_b  <= 1'b0;
        r_nmi_cnt <= NMI_CW'(NMI_WIDTH);
      end else if (!SNDNMI_b) begin
        if (r_nmi_cnt == NMI_CW'(1)) begin
          SNDNMI_b  <= 1'b1;
          r_nmi_cnt <= '0;
        end else begin
          r_nmi_cnt <= r_nmi_cnt - NMI_CW'(1);
        end
      end

      if (snd_rst_req) begin
        r_state   <= ST_HOLD;
        r_rst_cnt <= RST_CW'(RST_CYCLES);
        SNDRST_b  <= 1'b0;
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (r_rst_cnt == RST_CW'(1)) begin
              r_state   <= ST_RUN;
              r_rst_cnt <= '0;
              SNDRST_b  <= 1'b1;
            end else begin
              r_rst_cnt <= r_rst_cnt - RST_CW'(1);
            end
          end
          default: begin
            r_state <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_comm_latch.sv
// Bench for sound_comm_latch: directed steps plus random traffic, checked
// against a cycle-indexed behavioural model of the port.
module tb_sound_comm_latch;

  localparam int NMI_W = 4;
  localparam int RST_C = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] main_din;
  logic       main_wr_b;
  logic       main_rd_b;
  logic [7:0] main_dout;
  logic       main_irq;
  logic [3:0] main_status;
  logic       ovr_clr;
  logic       snd_rst_req;
  logic [7:0] SDin68k;
  logic [7:0] SDout68k;
  logic       WR68k_b;
  logic       RD68k_b;
  logic       SNDNMI_b;
  logic       ctrl_SNDBUF;
  logic       ctrl_68kBUF;
  logic       SNDRST_b;

  sound_comm_latch #(.NMI_WIDTH(NMI_W), .RST_CYCLES(RST_C)) dut (
    .clk(clk), .reset(reset), .main_din(main_din), .main_wr_b(main_wr_b),
    .main_rd_b(main_rd_b), .main_dout(main_dout), .main_irq(main_irq),
    .main_status(main_status), .ovr_clr(ovr_clr), .snd_rst_req(snd_rst_req),
    .SDin68k(SDin68k), .SDout68k(SDout68k), .WR68k_b(WR68k_b), .RD68k_b(RD68k_b),
    .SNDNMI_b(SNDNMI_b), .ctrl_SNDBUF(ctrl_SNDBUF), .ctrl_68kBUF(ctrl_68kBUF),
    .SNDRST_b(SNDRST_b)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Model: edge index since reset release, and the edge indices at which the
  // sound reset and NMI pulse end.
  int         m_cyc;
  int         m_run_at;
  int         m_nmi_until;
  logic       m_pw, m_pr, m_psw, m_psr;
  logic [7:0] m_sdin, m_dout;
  logic       m_sbuf, m_mbuf, m_sovr, m_movr;

  task automatic model_reset();
    m_cyc = 0; m_run_at = RST_C; m_nmi_until = 0;
    m_pw = 1; m_pr = 1; m_psw = 1; m_psr = 1;
    m_sdin = 0; m_dout = 0;
    m_sbuf = 0; m_mbuf = 0; m_sovr = 0; m_movr = 0;
  endtask

  task automatic model_edge();
    logic hold, wf, rf, swf, srf;
    if (reset) begin
      model_reset();
      return;
    end
    hold = snd_rst_req || (m_cyc < m_run_at);
    wf  = m_pw  && !main_wr_b;
    rf  = m_pr  && !main_rd_b;
    swf = m_psw && !WR68k_b;
    srf = m_psr && !RD68k_b;
    m_cyc = m_cyc + 1;
    if (wf) m_sdin = main_din;
    if (!hold && swf) m_dout = SDout68k;
    if (!hold && wf && m_sbuf) m_sovr = 1; else if (ovr_clr) m_sovr = 0;
    if (!hold && swf && m_mbuf) m_movr = 1; else if (ovr_clr) m_movr = 0;
    if (hold) begin
      m_sbuf = 0; m_mbuf = 0; m_nmi_until = 0;
    end else begin
      if (wf) m_sbuf = 1; else if (srf) m_sbuf = 0;
      if (swf) m_mbuf = 1; else if (rf) m_mbuf = 0;
      if (wf) m_nmi_until = m_cyc + NMI_W;
    end
    if (snd_rst_req) m_run_at = m_cyc + RST_C;
    m_pw = main_wr_b; m_pr = main_rd_b; m_psw = WR68k_b; m_psr = RD68k_b;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("SDin68k", SDin68k, m_sdin);
    chk("main_dout", main_dout, m_dout);
    chk("main_status", 8'(main_status), 8'({m_sovr, m_movr, m_mbuf, m_sbuf}));
    chk("main_irq", 8'(main_irq), 8'(m_mbuf));
    chk("SNDNMI_b", 8'(SNDNMI_b), 8'(m_cyc >= m_nmi_until));
    chk("SNDRST_b", 8'(SNDRST_b), 8'(m_cyc >= m_run_at));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  int n;

  initial begin
    reset = 1; main_din = 0; main_wr_b = 1; main_rd_b = 1; ovr_clr = 0;
    snd_rst_req = 0; SDout68k = 0; WR68k_b = 1; RD68k_b = 1;
    model_reset();
    tick(); tick();
    chk("reset_status", 8'(main_status), 8'h00);
    chk("reset_sndrst", 8'(SNDRST_b), 8'h00);
    reset = 0;

    // Sound reset hold length after reset release.
    n = 0;
    while (SNDRST_b !== 1'b1 && n < 40) begin tick(); n++; end
    chk("rst_len", 8'(n), 8'(RST_C));
    chk("idle_nmi", 8'(SNDNMI_b), 8'h01);
    chk("idle_status", 8'(main_status), 8'h00);

    // Command write and NMI width, then 6502 read.
    main_din = 8'hA5; main_wr_b = 0; tick(); main_wr_b = 1;
    chk("cmd_data", SDin68k, 8'hA5);
    chk("cmd_full", 8'(ctrl_SNDBUF), 8'h01);
    n = 0;
    while (SNDNMI_b === 1'b0 && n < 20) begin n++; tick(); end
    chk("nmi_len", 8'(n), 8'(NMI_W));
    RD68k_b = 0; tick(); RD68k_b = 1;
    chk("cmd_read_flag", 8'(ctrl_SNDBUF), 8'h00);
    chk("cmd_read_hold", SDin68k, 8'hA5);

    // Reply write, then 68k read clears irq.
    SDout68k = 8'h3C; WR68k_b = 0; tick(); WR68k_b = 1;
    chk("rep_data", main_dout, 8'h3C);
    chk("rep_irq", 8'(main_irq), 8'h01);
    main_rd_b = 0; tick(); main_rd_b = 1;
    chk("rep_irq_clr", 8'(main_irq), 8'h00);

    // Command overrun.
    main_din = 8'h11; main_wr_b = 0; tick(); main_wr_b = 1; tick();
    main_din = 8'h22; main_wr_b = 0; tick(); main_wr_b = 1; tick();
    chk("ovr_cmd_data", SDin68k, 8'h22);
    chk("snd_ovr_set", 8'(main_status[3]), 8'h01);
    ovr_clr = 1; tick(); ovr_clr = 0;
    chk("snd_ovr_clr", 8'(main_status[3]), 8'h00);

    // Reply overrun.
    SDout68k = 8'h44; WR68k_b = 0; tick(); WR68k_b = 1; tick();
    SDout68k = 8'h55; WR68k_b = 0; tick(); WR68k_b = 1; tick();
    chk("ovr_rep_data", main_dout, 8'h55);
    chk("main_ovr_set", 8'(main_status[2]), 8'h01);
    ovr_clr = 1; tick(); ovr_clr = 0;
    chk("main_ovr_clr", 8'(main_status[2]), 8'h00);

    // Reply write and 68k read on the same edge: set wins.
    SDout68k = 8'h99; WR68k_b = 0; main_rd_b = 0; tick(); WR68k_b = 1; main_rd_b = 1;
    chk("simul_flag", 8'(ctrl_68kBUF), 8'h01);
    chk("simul_data", main_dout, 8'h99);

    // Reset request with both flags set and an NMI pulse running.
    main_din = 8'h66; main_wr_b = 0; tick(); main_wr_b = 1;
    chk("pre_req_nmi", 8'(SNDNMI_b), 8'h00);
    snd_rst_req = 1; tick(); snd_rst_req = 0;
    chk("req_nmi", 8'(SNDNMI_b), 8'h01);
    chk("req_flags", 8'(main_status[1:0]), 8'h00);
    chk("req_sndrst", 8'(SNDRST_b), 8'h00);
    main_din = 8'h77; main_wr_b = 0; tick(); main_wr_b = 1;
    n = 1;
    chk("hold_data", SDin68k, 8'h77);
    chk("hold_flag", 8'(ctrl_SNDBUF), 8'h00);
    chk("hold_nmi", 8'(SNDNMI_b), 8'h01);
    while (SNDRST_b !== 1'b1 && n < 40) begin tick(); n++; end
    chk("req_rst_len", 8'(n), 8'(RST_C));

    // Random traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 1500; i++) begin
      main_din    = 8'($urandom);
      SDout68k    = 8'($urandom);
      main_wr_b   = ($urandom_range(0, 3) != 0);
      main_rd_b   = ($urandom_range(0, 3) != 0);
      WR68k_b     = ($urandom_range(0, 3) != 0);
      RD68k_b     = ($urandom_range(0, 3) != 0);
      ovr_clr     = ($urandom_range(0, 15) == 0);
      snd_rst_req = ($urandom_range(0, 99) == 0);
      if (i == 700) begin
        reset = 1;
        #1;
        model_reset();
        check_all();
        tick(); tick();
        reset = 0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sound_comm_latch.md
Name: sound_comm_latch

Overview:
- Main-CPU (68010) side of the 68k↔6502 sound communication port. Provides the command latch toward the sound CPU and the reply latch back from it.
- Provides the two buffer-full flags read by the sound CPU's coin/status port, the sound NMI pulse, the main-CPU reply interrupt, and the sound-system reset generator (SNDRST_b).
- Counterpart of the sound-side comm logic that drives WR68k_b/RD68k_b and consumes SDin68k/SNDNMI_b.

Parameters:
- NMI_WIDTH, 4, clk cycles SNDNMI_b is held low per command write (≥1).
- RST_CYCLES, 16, clk cycles SNDRST_b is held low after reset or a reset request (≥2).

Ports:
- clk  input  1  system clock; all inputs synchronous to it.
- reset  input  1  asynchronous, active-high reset.
- main_din  input  8  command byte from 68k data bus.
- main_wr_b  input  1  68k command-latch write strobe, active low (level).
- main_rd_b  input  1  68k reply-latch read strobe, active low (level).
- main_dout  output  8  reply byte to 68k.
- main_irq  output  1  active-high interrupt to 68k: reply pending.
- main_status  output  4  {snd_ovr, main_ovr, ctrl_68kBUF, ctrl_SNDBUF}.
- ovr_clr  input  1  one-cycle pulse, clears both overrun flags.
- snd_rst_req  input  1  one-cycle pulse, requests sound-system reset.
- SDin68k  output  8  command byte to sound CPU.
- SDout68k  input  8  reply byte from sound CPU.
- WR68k_b  input  1  sound-side reply write strobe, active low.
- RD68k_b  input  1  sound-side command read strobe, active low.
- SNDNMI_b  output  1  sound CPU NMI, active low.
- ctrl_SNDBUF  output  1  high = command latch full (unread by 6502).
- ctrl_68kBUF  output  1  high = reply latch full (unread by 68k).
- SNDRST_b  output  1  sound-system reset, active low.

Behaviour:
- All strobes are edge-detected: an action fires on the clk edge where the strobe is first sampled low (previous sample high). A strobe held low fires once.
- Previous-sample registers reset to 1.
- Reset values:
  - SDin68k = 0, main_dout = 0.
  - ctrl_SNDBUF = 0, ctrl_68kBUF = 0.
  - main_ovr = 0, snd_ovr = 0.
  - SNDNMI_b = 1, main_irq = 0.
  - SNDRST_b = 0, with the reset counter loaded to RST_CYCLES.
- Command write (main_wr_b fall):
  - SDin68k <= main_din; ctrl_SNDBUF <= 1 on the same edge (visible next cycle).
  - If ctrl_SNDBUF was already 1: data is overwritten and snd_ovr <= 1 (sticky).
  - If SNDRST_b = 1: SNDNMI_b <= 0 and the NMI counter is loaded with NMI_WIDTH. SNDNMI_b returns to 1 after exactly NMI_WIDTH cycles low.
  - A write during an active pulse reloads the counter, so the low period is extended and there is no new falling edge.
- Command read (RD68k_b fall): ctrl_SNDBUF <= 0. SDin68k is held (not cleared).
- Reply write (WR68k_b fall):
  - main_dout <= SDout68k; ctrl_68kBUF <= 1.
  - If ctrl_68kBUF was already 1: data is overwritten and main_ovr <= 1.
- Reply read (main_rd_b fall): ctrl_68kBUF <= 0. main_dout is held.
- main_irq = ctrl_68kBUF (registered level; deasserts the cycle after the clearing read).
- Simultaneous set and clear of the same flag in one cycle: set wins (flag = 1).
  - The read returns the pre-write data, because the output register updates on that edge.
- Overrun: ovr_clr clears both overrun flags. If an overrun occurs in the same cycle as ovr_clr, the set wins.
- Sound reset state machine, states RUN and HOLD:
  - Reset enters HOLD. snd_rst_req in any state enters HOLD and reloads the counter to RST_CYCLES.
  - HOLD: SNDRST_b = 0; counter decrements each cycle; at 0, go to RUN with SNDRST_b = 1.
  - In HOLD: ctrl_SNDBUF and ctrl_68kBUF are forced to 0; WR68k_b and RD68k_b edges are ignored; SNDNMI_b is forced to 1 and the NMI counter is cleared.
  - In HOLD: 68k writes still latch SDin68k but do not set ctrl_SNDBUF and do not pulse NMI. 68k reads still clear, with no effect.
  - Overrun flags and main_dout survive HOLD.
- Asynchronous reset mid-operation: all state returns to reset values immediately, including aborting an NMI pulse.
- No combinational path from any input to any output.

Test Plan:
- Reset released, idle → SNDRST_b low exactly 16 cycles then 1; SNDNMI_b = 1; both flags = 0; main_status = 4'b0000.
- 68k writes 8'hA5 → SDin68k = A5 and ctrl_SNDBUF = 1 next cycle; SNDNMI_b low exactly 4 cycles. Then RD68k_b pulse → ctrl_SNDBUF = 0, SDin68k still A5.
- 6502 writes 8'h3C via WR68k_b → main_dout = 3C, ctrl_68kBUF = 1, main_irq = 1. Then main_rd_b pulse → main_irq = 0 next cycle.
- Two 68k writes 8'h11 then 8'h22 with no read → SDin68k = 22, snd_ovr = 1. Then ovr_clr → main_status[3] = 0. Repeat the same check with main_ovr on the reply latch.
- WR68k_b fall and main_rd_b fall in the same cycle with ctrl_68kBUF = 1 → ctrl_68kBUF stays 1, main_dout = new byte.
- snd_rst_req while both flags are set and an NMI pulse is active → SNDNMI_b = 1 next cycle, flags 0, SNDRST_b low 16 cycles. A 68k write of 8'h77 during HOLD → SDin68k = 77, ctrl_SNDBUF = 0, no NMI.
